tri_pixel_collector: RTL and testbench
======================================

Name: tri_pixel_collector

Overview:
- Downstream consumer of the triangle rasteriser's output stream (busy/po/xo/yo).
- Captures every emitted pixel into an on-chip bitmap of (1<<W) x (1<<W) pixels.
- Maintains the pixel count, the bounding box and a duplicate-pixel flag.
- Once the rasteriser drops busy, the bitmap can be read out row by row for checking or display.

Parameters:
W, 3, coordinate width; the grid is (1<<W) x (1<<W), so 8x8 by default.

Ports:
clk  in  1  system clock; all state is updated on the rising edge
reset  in  1  synchronous reset, active-low
busy_in  in  1  rasteriser busy
po_in  in  1  rasteriser pixel-valid strobe
xo_in  in  W  pixel x coordinate
yo_in  in  W  pixel y coordinate
clr  in  1  clear the collected frame
rd_req  in  1  row read request
rd_row  in  W  row index to read
rd_valid  out  1  read data valid
rd_data  out  1<<W  row bitmap; bit i is pixel (x=i, y=rd_row)
done  out  1  frame complete, readout allowed
pix_cnt  out  2W+1  number of distinct pixels captured
xmin, xmax, ymin, ymax  out  W each  bounding box of captured pixels
dup_err  out  1  sticky flag: a pixel was emitted twice

Behaviour:
- Reset is sampled on the rising clk edge while reset==0. The block enters IDLE and outputs take these values:
  - bitmap = 0, pix_cnt = 0, dup_err = 0, done = 0
  - rd_valid = 0, rd_data = 0
  - xmin = ymin = all-ones, xmax = ymax = 0
  - Reset applies in any state, including mid-COLLECT.
- The block keeps busy_q, a registered copy of busy_in, which is 0 after reset. A rise is busy_in=1 while busy_q=0.
- States are IDLE, COLLECT and DONE. done=1 only in DONE.
- IDLE:
  - A busy rise moves the block to COLLECT.
  - po_in and rd_req are ignored.
  - clr re-clears the frame state (same values as reset) and the block stays in IDLE.
- COLLECT:
  - In each cycle with po_in=1, pixel (xo_in, yo_in) is processed:
    - If the pixel's bit is 0: set the bit, increment pix_cnt, and update the box with xmin=min, xmax=max, ymin=min, ymax=max.
    - If the bit is already 1: set dup_err; pix_cnt and the box are unchanged.
  - When busy_in==0 the block moves to DONE next cycle. A po_in=1 sampled in that same cycle is still captured.
  - clr and rd_req are ignored in COLLECT.
- DONE:
  - rd_req=1 at edge N gives rd_valid=1 and rd_data=bitmap[rd_row] after edge N, so both are valid in cycle N+1. This is 1-cycle latency.
  - Back-to-back requests are allowed: one row per cycle.
  - rd_valid=0 in any cycle that follows a cycle without an accepted request. rd_data holds its last value.
  - clr=1 with no busy rise: clear the frame state and move to IDLE.
  - Busy rise, with or without clr: auto-clear the frame state, then COLLECT next cycle. A po_in in the rise cycle is dropped. The rasteriser never asserts po in its first busy cycle.
  - When a clear and a read request occur in the same cycle, the clear wins and rd_valid=0.
- Widths:
  - pix_cnt saturates at 1<<(2W). It cannot overflow without duplicates, because duplicates do not count.
  - The box outputs are meaningful only when pix_cnt>0.
- Coordinates are always in range because the ports are exactly W bits wide.

Test Plan:
- Triangle fill: reset, then busy rise, then po pixels for x>=1, y>=1, x+y<=6, then busy fall.
  - Expect done=1, pix_cnt=15, xmin=ymin=1, xmax=ymax=5, dup_err=0.
  - rd_row=1 gives rd_data=0x3E; rd_row=5 gives 0x02; rd_row=0 gives 0x00.
- Duplicate: in COLLECT, po (3,4) twice, then busy falls.
  - Expect pix_cnt=1, dup_err=1, rd_row=4 gives 0x08.
- Last pixel on busy fall: po_in=1 at (7,7) in the same cycle busy_in=0.
  - Expect (7,7) captured, xmax=ymax=7, and DONE next cycle.
- Back-to-back reads: rd_req held for rows 0..7 over 8 cycles.
  - Expect rd_valid=1 for 8 consecutive cycles, each 1 cycle after its request.
  - rd_req in IDLE or COLLECT gives rd_valid=0.
- Auto-clear:
  - In DONE with pix_cnt=15, busy rises. Expect pix_cnt=0, bitmap=0, dup_err=0 next cycle, and state COLLECT.
  - In DONE, clr alone. Expect IDLE with done=0.
- Reset mid-COLLECT: reset=0 for one cycle after 5 pixels.
  - Expect all outputs at their reset values and state IDLE.
  - Later busy_in=0 with po_in=1 captures nothing.

Source files
------------

// File: rtl/tri_pixel_collector.sv
// Collects the triangle rasteriser's pixel stream into a (1<<W)x(1<<W) bitmap,
// tracking pixel count, bounding box and duplicates; rows are readable once done.
module tri_pixel_collector #(
  parameter int unsigned W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busy_in,
  input  logic                 po_in,
  input  logic [W-1:0]         xo_in,
  input  logic [W-1:0]         yo_in,
  input  logic                 clr,
  input  logic                 rd_req,
  input  logic [W-1:0]         rd_row,
  output logic                 rd_valid,
  output logic [(1<<W)-1:0]    rd_data,
  output logic                 done,
  output logic [2*W:0]         pix_cnt,
  output logic [W-1:0]         xmin,
  output logic [W-1:0]         xmax,
  output logic [W-1:0]         ymin,
  output logic [W-1:0]         ymax,
  output logic                 dup_err
);

  localparam int unsigned N = 1 << W;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          r_state;
  logic            r_busy_q;
  logic [N-1:0]    r_bitmap [N];
  logic [2*W:0]    r_pix_cnt;
  logic [W-1:0]    r_xmin, r_xmax, r_ymin, r_ymax;
  logic            r_dup_err;
  logic            r_done;
  logic            r_rd_valid;
  logic [N-1:0]    r_rd_data;

  logic            w_rise;
  logic            w_clear;
  logic            w_capture;
  logic            w_hit;

  always_comb begin
    w_rise    = busy_in & ~r_busy_q;
    w_clear   = ((r_state == IDLE) && clr) || ((r_state == DONE) && (w_rise || clr));
    w_capture = (r_state == COLLECT) && po_in;
    w_hit     = r_bitmap[yo_in][xo_in];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_busy_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) r_bitmap[i] <= '0;
      r_pix_cnt  <= '0;
      r_xmin     <= '1;
      r_xmax     <= '0;
      r_ymin     <= '1;
      r_ymax     <= '0;
      r_dup_err  <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_busy_q   <= busy_in;
      r_rd_valid <= 1'b0;

      // Frame clear and pixel capture are mutually exclusive by state.
      if (w_clear) begin
        for (int unsigned i = 0; i < N; i++) r_bitmap[i] <= '0;
        r_pix_cnt <= '0;
        r_xmin    <= '1;
        r_xmax    <= '0;
        r_ymin    <= '1;
        r_ymax    <= '0;
        r_dup_err <= 1'b0;
      end else if (w_capture) begin
        if (w_hit) begin
          r_dup_err <= 1'b1;
        end else begin
          r_bitmap[yo_in][xo_in] <= 1'b1;
          // Max count is exactly 1<<(2W), so the MSB marks saturation.
          if (!r_pix_cnt[2*W]) r_pix_cnt <= r_pix_cnt + 1'b1;
          if (xo_in < r_xmin) r_xmin <= xo_in;
          if (xo_in > r_xmax) r_xmax <= xo_in;
          if (yo_in < r_ymin) r_ymin <= yo_in;
          if (yo_in > r_ymax) r_ymax <= yo_in;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_rise) r_state <= COLLECT;
        end
        COLLECT: begin
          if (!busy_in) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          if (w_rise) begin
            r_state <= COLLECT;
            r_done  <= 1'b0;
          end else if (clr) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else if (rd_req) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_bitmap[rd_row];
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign done     = r_done;
  assign pix_cnt  = r_pix_cnt;
  assign xmin     = r_xmin;
  assign xmax     = r_xmax;
  assign ymin     = r_ymin;
  assign ymax     = r_ymax;
  assign dup_err  = r_dup_err;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed and randomized checks of tri_pixel_collector against a set-of-pixels
// reference model; count and box are derived from the model bitmap on demand.
module tb_tri_pixel_collector;

  localparam int W = 3;
  localparam int N = 1 << W;

  logic             clk;
  logic             reset;
  logic             busy_in;
  logic             po_in;
  logic [W-1:0]     xo_in;
  logic [W-1:0]     yo_in;
  logic             clr;
  logic             rd_req;
  logic [W-1:0]     rd_row;
  logic             rd_valid;
  logic [N-1:0]     rd_data;
  logic             done;
  logic [2*W:0]     pix_cnt;
  logic [W-1:0]     xmin, xmax, ymin, ymax;
  logic             dup_err;

  int n_pass  = 0;
  int n_total = 0;

  bit m_bmp [N][N];   // [y][x]
  bit m_dup;

  tri_pixel_collector #(.W(W)) dut (
    .clk(clk), .reset(reset), .busy_in(busy_in), .po_in(po_in),
    .xo_in(xo_in), .yo_in(yo_in), .clr(clr), .rd_req(rd_req), .rd_row(rd_row),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .pix_cnt(pix_cnt),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax), .dup_err(dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) m_bmp[y][x] = 1'b0;
    m_dup = 1'b0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) c += int'(m_bmp[y][x]);
    return c;
  endfunction

  function automatic logic [N-1:0] model_row(input int r);
    logic [N-1:0] v = '0;
    for (int x = 0; x < N; x++) v[x] = m_bmp[r][x];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y, input bit busy);
    po_in   = 1'b1;
    xo_in   = W'(x);
    yo_in   = W'(y);
    busy_in = busy;
    if (m_bmp[y][x]) m_dup = 1'b1;
    else m_bmp[y][x] = 1'b1;
    tick();
    po_in = 1'b0;
  endtask

  task automatic chk_frame(input string tag);
    int xmn = N - 1, xmx = 0, ymn = N - 1, ymx = 0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        if (m_bmp[y][x]) begin
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
    check({tag, ".cnt"},  32'(pix_cnt), 32'(model_count()));
    check({tag, ".dup"},  32'(dup_err), 32'(m_dup));
    check({tag, ".xmin"}, 32'(xmin), 32'(xmn));
    check({tag, ".xmax"}, 32'(xmax), 32'(xmx));
    check({tag, ".ymin"}, 32'(ymin), 32'(ymn));
    check({tag, ".ymax"}, 32'(ymax), 32'(ymx));
  endtask

  task automatic rd_all(input string tag);
    for (int r = 0; r < N; r++) begin
      rd_req = 1'b1;
      rd_row = W'(r);
      tick();
      check($sformatf("%s.vld%0d", tag, r), 32'(rd_valid), 32'd1);
      check($sformatf("%s.row%0d", tag, r), 32'(rd_data), 32'(model_row(r)));
    end
    rd_req = 1'b0;
    tick();
    check({tag, ".vld_off"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; busy_in = 1'b0; po_in = 1'b0; xo_in = '0; yo_in = '0;
    clr = 1'b0; rd_req = 1'b0; rd_row = '0;
    model_clear();

    // Reset values
    tick(); tick();
    reset = 1'b1;
    check("rst.done", 32'(done), 32'd0);
    check("rst.rdv", 32'(rd_valid), 32'd0);
    check("rst.rdd", 32'(rd_data), 32'd0);
    check("rst.xmin", 32'(xmin), 32'd7);
    check("rst.ymin", 32'(ymin), 32'd7);
    chk_frame("rst");

    // Read request in IDLE is ignored
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("idle.rdv", 32'(rd_valid), 32'd0);

    // Triangle fill, with a read request held during COLLECT
    busy_in = 1'b1; tick();
    check("tri.done0", 32'(done), 32'd0);
    rd_req = 1'b1;
    for (int y = 1; y < N; y++)
      for (int x = 1; x < N; x++)
        if (x + y <= 6) px(x, y, 1'b1);
    check("col.rdv", 32'(rd_valid), 32'd0);
    rd_req = 1'b0;
    busy_in = 1'b0; tick();
    check("tri.done", 32'(done), 32'd1);
    check("tri.cnt15", 32'(pix_cnt), 32'd15);
    check("tri.xmin1", 32'(xmin), 32'd1);
    check("tri.ymax5", 32'(ymax), 32'd5);
    chk_frame("tri");
    rd_all("tri");
    rd_req = 1'b1; rd_row = 3'd1; tick();
    check("tri.row1", 32'(rd_data), 32'h3E);
    rd_row = 3'd5; tick();
    check("tri.row5", 32'(rd_data), 32'h02);
    rd_row = 3'd0; tick();
    check("tri.row0", 32'(rd_data), 32'h00);

    // Auto-clear on busy rise in DONE; po and rd_req in that cycle are dropped
    busy_in = 1'b1; po_in = 1'b1; xo_in = '0; yo_in = '0; rd_req = 1'b1;
    tick();
    po_in = 1'b0; rd_req = 1'b0;
    model_clear();
    check("aclr.cnt0", 32'(pix_cnt), 32'd0);
    check("aclr.done", 32'(done), 32'd0);
    check("aclr.rdv", 32'(rd_valid), 32'd0);
    chk_frame("aclr");

    // Duplicate pixel
    px(3, 4, 1'b1);
    px(3, 4, 1'b1);
    busy_in = 1'b0; tick();
    check("dup.done", 32'(done), 32'd1);
    check("dup.cnt1", 32'(pix_cnt), 32'd1);
    check("dup.flag", 32'(dup_err), 32'd1);
    chk_frame("dup");
    rd_req = 1'b1; rd_row = 3'd4; tick(); rd_req = 1'b0;
    check("dup.row4", 32'(rd_data), 32'h08);

    // clr alone in DONE returns to IDLE; IDLE ignores po and rd_req
    clr = 1'b1; tick(); clr = 1'b0;
    model_clear();
    check("clr.done", 32'(done), 32'd0);
    chk_frame("clr");
    po_in = 1'b1; xo_in = 3'd1; yo_in = 3'd1; rd_req = 1'b1; tick();
    po_in = 1'b0; rd_req = 1'b0;
    check("idle.po", 32'(pix_cnt), 32'd0);
    check("idle.rdv2", 32'(rd_valid), 32'd0);

    // Random frame, last pixel (7,7) arrives with busy falling
    busy_in = 1'b1; tick();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) px(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), 1'b1);
      else tick();
    end
    px(7, 7, 1'b0);
    check("rnd.done", 32'(done), 32'd1);
    check("rnd.xmax7", 32'(xmax), 32'd7);
    check("rnd.ymax7", 32'(ymax), 32'd7);
    chk_frame("rnd");
    rd_all("rnd");

    // Clear and read in the same cycle: clear wins
    clr = 1'b1; rd_req = 1'b1; tick(); clr = 1'b0; rd_req = 1'b0;
    model_clear();
    check("clrrd.rdv", 32'(rd_valid), 32'd0);
    check("clrrd.done", 32'(done), 32'd0);
    chk_frame("clrrd");

    // Full grid: pix_cnt reaches 1<<(2W)
    busy_in = 1'b1; tick();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) px(x, y, 1'b1);
    busy_in = 1'b0; tick();
    check("full.cnt64", 32'(pix_cnt), 32'd64);
    chk_frame("full");
    clr = 1'b1; tick(); clr = 1'b0;
    model_clear();

    // Reset in the middle of COLLECT
    busy_in = 1'b1; tick();
    for (int i = 0; i < 5; i++) px(i, i + 1, 1'b1);
    reset = 1'b0; tick();
    reset = 1'b1;
    model_clear();
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.rdv", 32'(rd_valid), 32'd0);
    check("mrst.rdd", 32'(rd_data), 32'd0);
    chk_frame("mrst");
    busy_in = 1'b0; po_in = 1'b1; xo_in = 3'd2; yo_in = 3'd2; tick();
    po_in = 1'b0;
    check("mrst.po_cnt", 32'(pix_cnt), 32'd0);
    tick();
    check("mrst.done2", 32'(done), 32'd0);
    chk_frame("mrst2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
